// File: rtl/instr_fetch_if.sv
// instr_fetch_if: code-memory read port, decoder length lookup port,
// instruction bundle valid/ready port and fetch redirect, grouped for instr_fetch.
interface instr_fetch_if #(
   parameter int unsigned PC_W = 16
);
   // code memory read channel
   logic [PC_W-1:0] code_addr;
   logic            code_rd;
   logic [7:0]      code_data;
   logic            code_valid;
   // decoder length lookup
   logic [7:0]      dec_opcode;
   logic [1:0]      dec_length;
   // instruction bundle
   logic            ins_valid;
   logic            ins_ready;
   logic [7:0]      ins_opcode;
   logic [7:0]      ins_op1;
   logic [7:0]      ins_op2;
   logic [1:0]      ins_length;
   logic [PC_W-1:0] ins_pc;
   logic            ins_illegal;
   // fetch redirect
   logic            branch_en;
   logic [PC_W-1:0] branch_addr;

   modport master (
      output code_addr, code_rd,
      input  code_data, code_valid,
      output dec_opcode,
      input  dec_length,
      output ins_valid, ins_opcode, ins_op1, ins_op2, ins_length, ins_pc, ins_illegal,
      input  ins_ready,
      input  branch_en, branch_addr
   );

   modport slave (
      input  code_addr, code_rd,
      output code_data, code_valid,
      input  dec_opcode,
      output dec_length,
      input  ins_valid, ins_opcode, ins_op1, ins_op2, ins_length, ins_pc, ins_illegal,
      output ins_ready,
      output branch_en, branch_addr
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: 8051 instruction fetch/assembly front end.
// Reads opcode and operand bytes from code memory one at a time starting at pc,
// asks the decoder for the instruction length, and presents a complete
// instruction bundle on a valid/ready port. branch_en redirects fetch at any time.
// Optional feature macro: IF_ILLEGAL_TRAP_EN (flag length-0 opcodes as illegal;
// when undefined they are fetched as 1-byte instructions and ins_illegal is 0).
module instr_fetch #(
   parameter int unsigned    PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic          clock,
   input  logic          reset,
   instr_fetch_if.master bus
);

   typedef enum logic [2:0] {
      F_OP  = 3'd0,
      F_B1  = 3'd1,
      F_B2  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] code_addr_q;
   logic            code_rd_q;
   logic            ins_valid_q;
   logic [7:0]      opcode_q;
   logic [7:0]      op1_q;
   logic [7:0]      op2_q;
   logic [1:0]      length_q;
   logic [PC_W-1:0] ins_pc_q;
   logic [1:0]      len_eff;
   logic            opcode_hit;

`ifdef IF_ILLEGAL_TRAP_EN
   logic            illegal_q;
   logic            illegal_det;
`endif

   // opcode byte is on code_data right now (capture cycle of the opcode read)
   assign opcode_hit = (state == F_OP) && bus.code_valid;

   // decoder sees the live byte during the capture cycle, else the captured opcode
   assign bus.dec_opcode = opcode_hit ? bus.code_data : opcode_q;

   // length-0 opcodes occupy one byte in both builds
   always_comb begin
      len_eff = (bus.dec_length == 2'd0) ? 2'd1 : bus.dec_length;
`ifdef IF_ILLEGAL_TRAP_EN
      illegal_det = (bus.dec_length == 2'd0);
`endif
   end

   assign bus.code_addr  = code_addr_q;
   assign bus.code_rd    = code_rd_q;
   assign bus.ins_valid  = ins_valid_q;
   assign bus.ins_opcode = opcode_q;
   assign bus.ins_op1    = op1_q;
   assign bus.ins_op2    = op2_q;
   assign bus.ins_length = length_q;
   assign bus.ins_pc     = ins_pc_q;
`ifdef IF_ILLEGAL_TRAP_EN
   assign bus.ins_illegal = illegal_q;
`else
   assign bus.ins_illegal = 1'b0;
`endif

   // fetch sequencer: state, pc, memory request and bundle registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= F_OP;
         pc          <= RESET_PC;
         code_addr_q <= RESET_PC;
         code_rd_q   <= 1'b0;
         ins_valid_q <= 1'b0;
         opcode_q    <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         length_q    <= '0;
         ins_pc_q    <= '0;
`ifdef IF_ILLEGAL_TRAP_EN
         illegal_q   <= 1'b0;
`endif
      end else if (bus.branch_en) begin
         pc          <= bus.branch_addr;
         ins_valid_q <= 1'b0;
         // A read still in flight must complete before a new address may be
         // issued; code_addr stays on the old address until the stale byte arrives.
         case (state)
            F_OP, F_B1, F_B2: begin
               if (bus.code_valid || !code_rd_q) begin
                  state       <= F_OP;
                  code_rd_q   <= 1'b1;
                  code_addr_q <= bus.branch_addr;
               end else begin
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               // stale byte arriving together with a second redirect ends the drain
               if (bus.code_valid) begin
                  state       <= F_OP;
                  code_rd_q   <= 1'b1;
                  code_addr_q <= bus.branch_addr;
               end
            end
            default: begin
               state       <= F_OP;
               code_rd_q   <= 1'b1;
               code_addr_q <= bus.branch_addr;
            end
         endcase
      end else begin
         case (state)
            F_OP: begin
               code_rd_q <= 1'b1;
               if (bus.code_valid) begin
                  opcode_q <= bus.code_data;
                  op1_q    <= '0;
                  op2_q    <= '0;
                  length_q <= len_eff;
                  ins_pc_q <= pc;
`ifdef IF_ILLEGAL_TRAP_EN
                  illegal_q <= illegal_det;
`endif
                  if (len_eff == 2'd1) begin
                     state       <= HOLD;
                     code_rd_q   <= 1'b0;
                     ins_valid_q <= 1'b1;
                  end else begin
                     state       <= F_B1;
                     code_addr_q <= pc + PC_W'(1);
                  end
               end
            end
            F_B1: begin
               if (bus.code_valid) begin
                  op1_q <= bus.code_data;
                  if (length_q == 2'd2) begin
                     state       <= HOLD;
                     code_rd_q   <= 1'b0;
                     ins_valid_q <= 1'b1;
                  end else begin
                     state       <= F_B2;
                     code_addr_q <= pc + PC_W'(2);
                  end
               end
            end
            F_B2: begin
               if (bus.code_valid) begin
                  op2_q       <= bus.code_data;
                  state       <= HOLD;
                  code_rd_q   <= 1'b0;
                  ins_valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.ins_ready) begin
                  pc          <= pc + PC_W'(length_q);
                  code_addr_q <= pc + PC_W'(length_q);
                  code_rd_q   <= 1'b1;
                  ins_valid_q <= 1'b0;
                  state       <= F_OP;
               end
            end
            DRAIN: begin
               if (bus.code_valid) begin
                  state       <= F_OP;
                  code_rd_q   <= 1'b1;
                  code_addr_q <= pc;
               end
            end
            default: begin
               state     <= F_OP;
               code_rd_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
